// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the logic unit: the 3-bit gate opcode enum and the
// single-bit gate function that the combinational core applies to every bit
// lane. Because every operation is purely bitwise, a one-bit function applied
// per lane covers any operand width without a width limit.
// -----------------------------------------------------------------------------
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,   // ~A, B ignored
        OP_ANDN = 3'd7    // A & ~B
    } op_e;

    // Gate function for one bit lane; the caller replicates it across WIDTH.
    function automatic logic logic_fn(input op_e op, input logic a, input logic b);
        logic y;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOTA: y = ~a;
            OP_ANDN: y = a & ~b;
            default: y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_core.sv
// -----------------------------------------------------------------------------
// logic_core
// Purely combinational gate array: applies the selected two-input gate to
// every bit of a and b and derives the reduction flags from the result.
//
// Ports:
//   op      in   op_e        gate select
//   a, b    in   WIDTH       operands
//   y       out  WIDTH       bitwise result
//   zero    out  1           y == 0
//   ones    out  1           y is all ones
//   parity  out  1           XOR-reduction of y
// -----------------------------------------------------------------------------
module logic_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             parity
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign y[i] = logic_fn(op, a[i], b[i]);
    end

    assign zero   = ~|y;
    assign ones   = &y;
    assign parity = ^y;

endmodule

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Registered bitwise logic unit with a single-entry valid/ready output stage,
// accumulator feedback for chained operations and a saturating count of
// accepted transactions.
//
// Ports:
//   clk, rst_n   in   clock, synchronous active-low reset
//   in_valid     in   transaction present
//   in_ready     out  block can accept this cycle (!out_valid || out_ready)
//   in_a, in_b   in   WIDTH operands (in_a ignored when in_acc=1)
//   in_op        in   3-bit gate select (logic_unit_pkg::op_e)
//   in_acc       in   use accumulator as operand A
//   acc_clr      in   clear the accumulator (applies before the transaction)
//   out_valid    out  result register holds an unconsumed result
//   out_ready    in   downstream accepts the result
//   out_y        out  WIDTH result
//   out_zero/out_ones/out_parity  out  flags registered alongside out_y
//   op_count     out  CNT_W accepted-transaction count, saturating
// -----------------------------------------------------------------------------
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic [CNT_W-1:0] op_count
);

    logic             valid_q,  valid_d;
    logic [WIDTH-1:0] y_q,      y_d;
    logic             zero_q,   zero_d;
    logic             ones_q,   ones_d;
    logic             parity_q, parity_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic             accept;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] core_y;
    logic             core_zero, core_ones, core_parity;

    // Single-entry stage: free when empty or being drained this cycle.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // A same-cycle clear is seen by the transaction it accompanies.
    assign acc_eff  = acc_clr ? '0 : acc_q;
    assign a_eff    = in_acc ? acc_eff : in_a;

    logic_core #(.WIDTH(WIDTH)) u_core (
        .op     (op_e'(in_op)),
        .a      (a_eff),
        .b      (in_b),
        .y      (core_y),
        .zero   (core_zero),
        .ones   (core_ones),
        .parity (core_parity)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        valid_d  = valid_q;
        y_d      = y_q;
        zero_d   = zero_q;
        ones_d   = ones_q;
        parity_d = parity_q;
        acc_d    = acc_eff;
        cnt_d    = cnt_q;

        if (accept) begin
            valid_d  = 1'b1;
            y_d      = core_y;
            zero_d   = core_zero;
            ones_d   = core_ones;
            parity_d = core_parity;
            acc_d    = core_y;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            // Drained with nothing new: drop valid, keep the last value.
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            y_q      <= '0;
            zero_q   <= 1'b1;
            ones_q   <= 1'b0;
            parity_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            y_q      <= y_d;
            zero_q   <= zero_d;
            ones_q   <= ones_d;
            parity_q <= parity_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_y      = y_q;
    assign out_zero   = zero_q;
    assign out_ones   = ones_q;
    assign out_parity = parity_q;
    assign op_count   = cnt_q;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's two-input gate block.
- Every standard two-input gate function is applied bitwise to WIDTH-bit operands, selected per transaction by an opcode.
- Results leave through a registered output stage with a valid/ready handshake. The stage also carries reduction flags, an accumulator feedback mode for chained operations, and a saturating transaction counter.
- Sits between a command source and any downstream consumer that can apply backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- CNT_W, 8, width of the accepted-transaction counter (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  input transaction present
- in_ready  output  1  block can accept a transaction this cycle
- in_a  input  WIDTH  operand A (ignored when in_acc=1)
- in_b  input  WIDTH  operand B
- in_op  input  3  gate select (see Behaviour)
- in_acc  input  1  use the accumulator as operand A
- acc_clr  input  1  clear the accumulator
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  downstream accepts the result
- out_y  output  WIDTH  result
- out_zero  output  1  out_y == 0
- out_ones  output  1  out_y is all ones
- out_parity  output  1  XOR-reduction of out_y
- op_count  output  CNT_W  number of accepted transactions, saturating

Behaviour:
- Reset: on a clk edge with rst_n=0:
  - out_valid=0, out_y=0, out_zero=1, out_ones=0, out_parity=0
  - accumulator=0, op_count=0
  - Reset overrides every other input, including a transaction in flight; the pending result is discarded.
- Opcode set (shared package):
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR
  - 6 NOTA (~A; B ignored)
  - 7 ANDN (A & ~B)
- Handshake:
  - in_ready = !out_valid || out_ready, combinational; this is a single-entry pipeline register.
  - Accept = in_valid && in_ready.
  - Latency: a result appears on out_y with out_valid=1 on the cycle after accept.
  - While out_valid=1 and out_ready=0, out_y and the flags hold stable and in_ready=0.
  - Full throughput is one result per cycle when out_ready=1.
  - On a cycle with out_valid=1, out_ready=1 and no accept, out_valid falls to 0 and out_y holds its last value.
- Operand A selection: effective A = in_acc ? accumulator : in_a.
- Accumulator:
  - On accept, accumulator <= result.
  - acc_clr without accept: accumulator <= 0.
  - acc_clr with accept: the clear applies first, so effective A = 0 when in_acc=1; then accumulator <= result of that transaction.
  - acc_clr does not affect out_valid or out_y.
- Flags are registered together with out_y; they are never computed from a stale value.
- op_count:
  - Increments by 1 on each accept.
  - Saturates at 2^CNT_W - 1 and does not wrap.
- Width: all ops are bitwise with no carries. For WIDTH=1, out_ones = out_y = out_parity.
- in_op values are always legal (3-bit field); there is no error path.

Decomposition:
- Package logic_unit_pkg holds:
  - the op_e enum (3-bit opcodes above)
  - a function logic_fn(op, a, b) returning WIDTH bits; parametrised via the function's argument width or a parametrised class-free macro, per team practice.
- Sub-module logic_core (purely combinational):
  - Inputs: op, a, b.
  - Outputs: y, zero, ones, parity.
  - Instantiated once by logic_unit_pipe, which owns the handshake, accumulator and counter.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, then release -> out_valid=0, out_y=0, out_zero=1, op_count=0; first accept appears the cycle after release.
- Op sweep, WIDTH=8, A=8'hA5, B=8'h3C, out_ready=1, one op per cycle:
  - op 0-7 -> 24, BD, DB, 42, 99, 66, 5A, 81
  - out_parity for 99 = 0, for BD = 0, for 81 = 0, for 24 = 0, for 5A = 0
  - out_zero=0 throughout; op_count=8
- Backpressure: out_ready=0 after the first result (AND -> 24) -> in_ready=0 and out_y stays 24 for 5 cycles with in_valid=1 and op=OR. Then raise out_ready -> OR result BD appears next cycle, with no loss or duplication.
- Accumulate: acc_clr=1 with accept of XOR, in_acc=1, B=0F -> out_y=0F. Then XOR, in_acc=1, B=F0 -> FF with out_ones=1. Then ANDN, in_acc=1, B=FF -> 00 with out_zero=1.
- Counter saturation, CNT_W=3: 9 accepted transactions -> op_count=7, unchanged by later accepts.
- Reset mid-operation: assert rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, accumulator=0, op_count=0; the stalled result is never delivered.
